// File: rtl/fp_pkg.sv
// Shared constants and types for the FP operand unpacker: precision codes,
// per-format exponent geometry and the packed classification word.
package fp_pkg;

    localparam int XLEN  = 64;
    localparam int EXPW  = 13;
    localparam int MANW  = 53;
    localparam int FRACW = MANW - 1;
    localparam int INFOW = 4 + EXPW;

    typedef enum logic [1:0] {
        PREC_ILL = 2'b00,
        PREC_H   = 2'b01,
        PREC_S   = 2'b10,
        PREC_D   = 2'b11
    } prec_e;

    localparam int EXPW_D = 11;
    localparam int EXPW_S = 8;
    localparam int EXPW_H = 5;

    localparam int BIAS_D = 1023;
    localparam int BIAS_S = 127;
    localparam int BIAS_H = 15;

    localparam logic [EXPW_D-1:0] EMAX_D = 11'h7FF;
    localparam logic [EXPW_D-1:0] EMAX_S = 11'h0FF;
    localparam logic [EXPW_D-1:0] EMAX_H = 11'h01F;

    localparam int INFO_ZERO = 16;
    localparam int INFO_NORM = 15;
    localparam int INFO_INF  = 14;
    localparam int INFO_NAN  = 13;

    typedef struct packed {
        logic            is_zero;
        logic            is_norm;
        logic            is_inf;
        logic            is_nan;
        logic [EXPW-1:0] exp;
    } info_t;

    // Exponent is carried at double width (11 bits) for every format; narrower
    // formats arrive zero-extended, so one classifier serves all three.
    function automatic info_t mk_info(input logic [EXPW_D-1:0] e,
                                      input logic [EXPW_D-1:0] emax,
                                      input logic              frac_nz);
        info_t r;
        r.is_zero = (e == '0) && !frac_nz;
        r.is_norm = (e != '0);
        r.is_inf  = (e == emax) && !frac_nz;
        r.is_nan  = (e == emax) && frac_nz;
        r.exp     = {{(EXPW - EXPW_D){1'b0}}, e};
        return r;
    endfunction

endpackage

// File: rtl/fp_unpack_pipe_if.sv
// Operand-in / classified-result-out bus of the unpacker.
// The slave modport is the pipeline's view; master is the producer/consumer side.
interface fp_unpack_pipe_if;
    import fp_pkg::*;

    logic              in_valid;
    logic              in_ready;
    logic [XLEN-1:0]   in_op;
    logic [1:0]        in_prec;
    logic              out_valid;
    logic              out_ready;
    logic [INFOW-1:0]  out_info;
    logic              out_sign;
    logic [MANW-1:0]   out_mant;
    logic              out_snan;
    logic              out_err;

    modport slave (
        input  in_valid, in_op, in_prec, out_ready,
        output in_ready, out_valid, out_info, out_sign, out_mant, out_snan, out_err
    );

    modport master (
        output in_valid, in_op, in_prec, out_ready,
        input  in_ready, out_valid, out_info, out_sign, out_mant, out_snan, out_err
    );

endinterface

// File: rtl/fp_classify.sv
// Combinational IEEE-754 field extraction and classification for double/single/half.
// Latency: none. Backpressure: n/a (pure function of op/prec).
module fp_classify
    import fp_pkg::*;
(
    input  logic [XLEN-1:0] op_i,
    input  logic [1:0]      prec_i,
    output info_t           info_o,
    output logic            sign_o,
    output logic [MANW-1:0] mant_o,
    output logic            snan_o,
    output logic            err_o
);

    logic [EXPW_D-1:0] e_raw;
    logic [EXPW_D-1:0] emax;
    logic [FRACW-1:0]  frac;
    logic              frac_nz;
    info_t             info_raw;

    // Fraction is left-aligned into 52 bits so its MSB is always frac[FRACW-1].
    always_comb begin
        e_raw  = '0;
        emax   = '0;
        frac   = '0;
        sign_o = 1'b0;
        err_o  = 1'b0;
        case (prec_i)
            PREC_D: begin
                sign_o = op_i[63];
                e_raw  = op_i[62:52];
                emax   = EMAX_D;
                frac   = op_i[51:0];
            end
            PREC_S: begin
                sign_o = op_i[31];
                e_raw  = {{(EXPW_D - EXPW_S){1'b0}}, op_i[30:23]};
                emax   = EMAX_S;
                frac   = {op_i[22:0], 29'b0};
            end
            PREC_H: begin
                sign_o = op_i[15];
                e_raw  = {{(EXPW_D - EXPW_H){1'b0}}, op_i[14:10]};
                emax   = EMAX_H;
                frac   = {op_i[9:0], 42'b0};
            end
            default: err_o = 1'b1;
        endcase
    end

    assign frac_nz  = (frac != '0);
    assign info_raw = mk_info(e_raw, emax, frac_nz);

    // An illegal precision must not look like a zero/inf, so gate the flags.
    always_comb begin
        info_o = info_raw;
        snan_o = info_raw.is_nan && !frac[FRACW-1];
        if (err_o) begin
            info_o = '0;
            snan_o = 1'b0;
        end
    end

    assign mant_o = {e_raw != '0, frac};

endmodule

// File: rtl/fp_unpack_pipe.sv
// Two-stage unpacker: S1 registers the raw operand, S2 registers the classified result.
// Latency: 2 cycles from accepted operand to out_valid; sustains 1 result/cycle.
// Backpressure: in_ready is combinational from stage occupancy and out_ready; S2 holds while stalled.
module fp_unpack_pipe
    import fp_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic               flush,
    fp_unpack_pipe_if.slave    bus
);

    logic              s1_vld_q, s1_vld_d;
    logic [XLEN-1:0]   s1_op_q;
    logic [1:0]        s1_prec_q;

    logic              s2_vld_q, s2_vld_d;
    info_t             s2_info_q;
    logic              s2_sign_q;
    logic [MANW-1:0]   s2_mant_q;
    logic              s2_snan_q;
    logic              s2_err_q;

    info_t             c_info;
    logic              c_sign;
    logic [MANW-1:0]   c_mant;
    logic              c_snan;
    logic              c_err;

    logic              s1_adv, s2_adv, s1_ld, s2_ld;

    assign s2_adv      = !s2_vld_q || bus.out_ready;
    assign s1_adv      = !s1_vld_q || s2_adv;
    assign bus.in_ready = s1_adv;

    // Flush only kills the valids; data registers keep their contents.
    assign s1_ld = s1_adv && bus.in_valid && !flush;
    assign s2_ld = s2_adv && s1_vld_q && !flush;

    always_comb begin
        s1_vld_d = s1_vld_q;
        s2_vld_d = s2_vld_q;
        if (flush) begin
            s1_vld_d = 1'b0;
            s2_vld_d = 1'b0;
        end else begin
            if (s1_adv) s1_vld_d = bus.in_valid;
            if (s2_adv) s2_vld_d = s1_vld_q;
        end
    end

    fp_classify u_classify (
        .op_i   (s1_op_q),
        .prec_i (s1_prec_q),
        .info_o (c_info),
        .sign_o (c_sign),
        .mant_o (c_mant),
        .snan_o (c_snan),
        .err_o  (c_err)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_vld_q  <= 1'b0;
            s1_op_q   <= '0;
            s1_prec_q <= '0;
            s2_vld_q  <= 1'b0;
            s2_info_q <= '0;
            s2_sign_q <= 1'b0;
            s2_mant_q <= '0;
            s2_snan_q <= 1'b0;
            s2_err_q  <= 1'b0;
        end else begin
            s1_vld_q <= s1_vld_d;
            s2_vld_q <= s2_vld_d;
            if (s1_ld) begin
                s1_op_q   <= bus.in_op;
                s1_prec_q <= bus.in_prec;
            end
            if (s2_ld) begin
                s2_info_q <= c_info;
                s2_sign_q <= c_sign;
                s2_mant_q <= c_mant;
                s2_snan_q <= c_snan;
                s2_err_q  <= c_err;
            end
        end
    end

    assign bus.out_valid = s2_vld_q;
    assign bus.out_info  = s2_info_q;
    assign bus.out_sign  = s2_sign_q;
    assign bus.out_mant  = s2_mant_q;
    assign bus.out_snan  = s2_snan_q;
    assign bus.out_err   = s2_err_q;

endmodule

// File: tb/tb_fp_unpack_pipe.sv
// Directed bench for fp_unpack_pipe: classification vectors, latency, backpressure,
// full-rate streaming, flush and asynchronous reset mid-stream.
module tb_fp_unpack_pipe;

    logic clk = 1'b0;
    logic rst_n;
    logic flush;

    fp_unpack_pipe_if bus();

    fp_unpack_pipe dut (
        .clk   (clk),
        .rst_n (rst_n),
        .flush (flush),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_bad = 0;

    // Drive one operand at full rate and wait (bounded) for its result.
    task automatic run_one(input logic [63:0] op, input logic [1:0] prec, output int lat,
                           output logic [16:0] info, output logic sign, output logic [52:0] mant,
                           output logic snan, output logic err);
        @(negedge clk);
        bus.in_valid  = 1'b1;
        bus.in_op     = op;
        bus.in_prec   = prec;
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.in_valid = 1'b0;
        lat = 1;
        while (!bus.out_valid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        info = bus.out_info;
        sign = bus.out_sign;
        mant = bus.out_mant;
        snan = bus.out_snan;
        err  = bus.out_err;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #12;
        n_vec++; if (bus.out_valid !== 1'b0) begin n_bad++; $display("FAIL reset_out_valid got %b want 0", bus.out_valid); end
        n_vec++; if (bus.out_info !== 17'h0) begin n_bad++; $display("FAIL reset_out_info got %h want 0", bus.out_info); end
        n_vec++; if (bus.out_mant !== 53'h0) begin n_bad++; $display("FAIL reset_out_mant got %h want 0", bus.out_mant); end
        n_vec++; if (bus.out_err !== 1'b0) begin n_bad++; $display("FAIL reset_out_err got %b want 0", bus.out_err); end
        n_vec++; if (bus.in_ready !== 1'b1) begin n_bad++; $display("FAIL reset_in_ready got %b want 1", bus.in_ready); end
        rst_n = 1'b1;
    endtask

    task automatic test_double();
        int lat; logic [16:0] info; logic sign; logic [52:0] mant; logic snan; logic err;
        run_one(64'h3FF0_0000_0000_0000, 2'b11, lat, info, sign, mant, snan, err);
        n_vec++; if (lat !== 2) begin n_bad++; $display("FAIL dbl_one_latency got %0d want 2", lat); end
        n_vec++; if (info !== 17'h083FF) begin n_bad++; $display("FAIL dbl_one_info got %h want 083ff", info); end
        n_vec++; if (mant !== 53'h10_0000_0000_0000) begin n_bad++; $display("FAIL dbl_one_mant got %h want 10000000000000", mant); end
        n_vec++; if ({sign, snan, err} !== 3'b000) begin n_bad++; $display("FAIL dbl_one_flags got %b want 000", {sign, snan, err}); end
        run_one(64'hFFF0_0000_0000_0000, 2'b11, lat, info, sign, mant, snan, err);
        n_vec++; if (info !== 17'h0C7FF) begin n_bad++; $display("FAIL dbl_ninf_info got %h want 0c7ff", info); end
        n_vec++; if (sign !== 1'b1) begin n_bad++; $display("FAIL dbl_ninf_sign got %b want 1", sign); end
    endtask

    task automatic test_single();
        int lat; logic [16:0] info; logic sign; logic [52:0] mant; logic snan; logic err;
        run_one(64'h0000_0000_7F80_0000, 2'b10, lat, info, sign, mant, snan, err);
        n_vec++; if (info !== 17'h0C0FF) begin n_bad++; $display("FAIL sgl_inf_info got %h want 0c0ff", info); end
        n_vec++; if (snan !== 1'b0) begin n_bad++; $display("FAIL sgl_inf_snan got %b want 0", snan); end
        run_one(64'h0000_0000_7F80_0001, 2'b10, lat, info, sign, mant, snan, err);
        n_vec++; if (info !== 17'h0A0FF) begin n_bad++; $display("FAIL sgl_snan_info got %h want 0a0ff", info); end
        n_vec++; if (snan !== 1'b1) begin n_bad++; $display("FAIL sgl_snan_flag got %b want 1", snan); end
        n_vec++; if (mant !== 53'h10_0000_2000_0000) begin n_bad++; $display("FAIL sgl_snan_mant got %h want 10000020000000", mant); end
        run_one(64'h0000_0000_7FC0_0000, 2'b10, lat, info, sign, mant, snan, err);
        n_vec++; if ({info, snan} !== {17'h0A0FF, 1'b0}) begin n_bad++; $display("FAIL sgl_qnan got %h/%b want 0a0ff/0", info, snan); end
        // Upper 32 bits are garbage and must be ignored for single precision.
        run_one(64'hDEAD_BEEF_3F80_0000, 2'b10, lat, info, sign, mant, snan, err);
        n_vec++; if ({info, sign} !== {17'h0807F, 1'b0}) begin n_bad++; $display("FAIL sgl_upper_ignored got %h/%b want 0807f/0", info, sign); end
    endtask

    task automatic test_half();
        int lat; logic [16:0] info; logic sign; logic [52:0] mant; logic snan; logic err;
        logic [52:0] m_exp;
        m_exp = 53'd1 << 42;
        run_one(64'h0000_0000_0000_0001, 2'b01, lat, info, sign, mant, snan, err);
        n_vec++; if (info !== 17'h0) begin n_bad++; $display("FAIL hlf_subn_info got %h want 0", info); end
        n_vec++; if (mant !== m_exp) begin n_bad++; $display("FAIL hlf_subn_mant got %h want %h", mant, m_exp); end
        run_one(64'h0000_0000_0000_8000, 2'b01, lat, info, sign, mant, snan, err);
        n_vec++; if (info !== 17'h10000) begin n_bad++; $display("FAIL hlf_nzero_info got %h want 10000", info); end
        n_vec++; if ({sign, mant} !== {1'b1, 53'h0}) begin n_bad++; $display("FAIL hlf_nzero_sign_mant got %b/%h want 1/0", sign, mant); end
        run_one(64'h0000_0000_0000_7C00, 2'b01, lat, info, sign, mant, snan, err);
        n_vec++; if (info !== 17'h0C01F) begin n_bad++; $display("FAIL hlf_inf_info got %h want 0c01f", info); end
    endtask

    task automatic test_illegal();
        int lat; logic [16:0] info; logic sign; logic [52:0] mant; logic snan; logic err;
        run_one(64'hFFF4_0000_0000_0000, 2'b00, lat, info, sign, mant, snan, err);
        n_vec++; if (lat !== 2) begin n_bad++; $display("FAIL ill_latency got %0d want 2", lat); end
        n_vec++; if (err !== 1'b1) begin n_bad++; $display("FAIL ill_err got %b want 1", err); end
        n_vec++; if ({info, mant, sign, snan} !== 72'h0) begin n_bad++; $display("FAIL ill_fields got %h/%h/%b/%b want all 0", info, mant, sign, snan); end
        run_one(64'h3FF0_0000_0000_0000, 2'b11, lat, info, sign, mant, snan, err);
        n_vec++; if ({err, info} !== {1'b0, 17'h083FF}) begin n_bad++; $display("FAIL ill_followup got %b/%h want 0/083ff", err, info); end
    endtask

    task automatic test_backpressure();
        logic [63:0] items [4];
        logic [16:0] exp_info [4];
        logic [16:0] held;
        int sent = 0, rcv = 0;
        held = '0;
        for (int i = 0; i < 4; i++) begin
            items[i]    = {1'b0, 11'(i + 1), 52'h0};
            exp_info[i] = 17'h08000 | 17'(i + 1);
        end
        for (int cyc = 0; cyc < 40 && rcv < 4; cyc++) begin
            @(negedge clk);
            bus.in_valid  = (sent < 4);
            bus.in_op     = items[(sent < 4) ? sent : 3];
            bus.in_prec   = 2'b11;
            bus.out_ready = (cyc >= 6);
            #1;
            if (cyc == 2) held = bus.out_info;
            if (cyc == 5) begin
                n_vec++; if (sent !== 2) begin n_bad++; $display("FAIL bp_accepted got %0d want 2", sent); end
                n_vec++; if (bus.in_ready !== 1'b0) begin n_bad++; $display("FAIL bp_in_ready got %b want 0", bus.in_ready); end
                n_vec++; if (bus.out_info !== held || held !== exp_info[0]) begin n_bad++; $display("FAIL bp_hold got %h (was %h) want %h", bus.out_info, held, exp_info[0]); end
            end
            if (bus.out_valid && bus.out_ready) begin
                n_vec++; if (bus.out_info !== exp_info[rcv]) begin n_bad++; $display("FAIL bp_order[%0d] got %h want %h", rcv, bus.out_info, exp_info[rcv]); end
                rcv++;
            end
            if (bus.in_valid && bus.in_ready) sent++;
        end
        @(negedge clk);
        bus.in_valid = 1'b0;
        #1;
        n_vec++; if (rcv !== 4) begin n_bad++; $display("FAIL bp_count got %0d want 4", rcv); end
        n_vec++; if (bus.out_valid !== 1'b0) begin n_bad++; $display("FAIL bp_no_dup got %b want 0", bus.out_valid); end
    endtask

    task automatic test_back_to_back();
        int sent = 0, rcv = 0, last = -1, stalls = 0;
        logic [16:0] i_exp;
        logic [52:0] m_exp;
        for (int cyc = 0; cyc < 20 && rcv < 8; cyc++) begin
            @(negedge clk);
            bus.out_ready = 1'b1;
            bus.in_valid  = (sent < 8);
            bus.in_prec   = 2'b01;
            bus.in_op     = {48'h0, 1'(sent & 1), 5'(sent + 1), 10'(sent)};
            #1;
            if (bus.in_valid && !bus.in_ready) stalls++;
            if (bus.out_valid) begin
                i_exp = 17'h08000 | 17'(rcv + 1);
                m_exp = {1'b1, 10'(rcv), 42'h0};
                n_vec++; if (bus.out_info !== i_exp) begin n_bad++; $display("FAIL b2b_info[%0d] got %h want %h", rcv, bus.out_info, i_exp); end
                n_vec++; if (bus.out_sign !== 1'(rcv & 1)) begin n_bad++; $display("FAIL b2b_sign[%0d] got %b want %b", rcv, bus.out_sign, 1'(rcv & 1)); end
                n_vec++; if (bus.out_mant !== m_exp) begin n_bad++; $display("FAIL b2b_mant[%0d] got %h want %h", rcv, bus.out_mant, m_exp); end
                rcv++;
                last = cyc;
            end
            if (bus.in_valid && bus.in_ready) sent++;
        end
        bus.in_valid = 1'b0;
        n_vec++; if (stalls !== 0) begin n_bad++; $display("FAIL b2b_stalls got %0d want 0", stalls); end
        n_vec++; if (rcv !== 8 || last !== 9) begin n_bad++; $display("FAIL b2b_rate got %0d results ending cycle %0d want 8 ending 9", rcv, last); end
    endtask

    task automatic test_flush();
        int lat, seen = 0; logic [16:0] info; logic sign; logic [52:0] mant; logic snan; logic err;
        @(negedge clk);
        bus.out_ready = 1'b0; bus.in_valid = 1'b1; bus.in_prec = 2'b11;
        bus.in_op = 64'h4000_0000_0000_0000;
        @(negedge clk);
        bus.in_op = 64'h4010_0000_0000_0000;
        @(negedge clk);
        // Both stages full; flush together with a new operand that in_ready would accept.
        flush = 1'b1; bus.out_ready = 1'b1; bus.in_op = 64'h4020_0000_0000_0000;
        @(negedge clk);
        flush = 1'b0; bus.in_valid = 1'b0;
        #1;
        n_vec++; if (bus.out_valid !== 1'b0) begin n_bad++; $display("FAIL flush_out_valid got %b want 0", bus.out_valid); end
        n_vec++; if (bus.out_info !== 17'h08400) begin n_bad++; $display("FAIL flush_data_kept got %h want 08400", bus.out_info); end
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (bus.out_valid) seen++;
        end
        n_vec++; if (seen !== 0) begin n_bad++; $display("FAIL flush_stale got %0d outputs want 0", seen); end
        run_one(64'h3FF0_0000_0000_0000, 2'b11, lat, info, sign, mant, snan, err);
        n_vec++; if (lat !== 2 || info !== 17'h083FF) begin n_bad++; $display("FAIL flush_recover got lat %0d info %h want 2/083ff", lat, info); end
    endtask

    task automatic test_reset_mid();
        int lat, seen = 0; logic [16:0] info; logic sign; logic [52:0] mant; logic snan; logic err;
        @(negedge clk);
        bus.out_ready = 1'b0; bus.in_valid = 1'b1; bus.in_prec = 2'b11;
        bus.in_op = 64'hFFF0_0000_0000_0000;
        @(negedge clk);
        bus.in_op = 64'h4000_0000_0000_0000;
        @(negedge clk);
        bus.in_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        n_vec++; if (bus.out_valid !== 1'b0) begin n_bad++; $display("FAIL arst_out_valid got %b want 0", bus.out_valid); end
        n_vec++; if ({bus.out_info, bus.out_sign, bus.out_mant} !== 71'h0) begin n_bad++; $display("FAIL arst_data got %h/%b/%h want 0", bus.out_info, bus.out_sign, bus.out_mant); end
        @(negedge clk);
        rst_n = 1'b1; bus.out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (bus.out_valid) seen++;
        end
        n_vec++; if (seen !== 0) begin n_bad++; $display("FAIL arst_stale got %0d outputs want 0", seen); end
        run_one(64'h0000_0000_3F80_0000, 2'b10, lat, info, sign, mant, snan, err);
        n_vec++; if (lat !== 2 || info !== 17'h0807F) begin n_bad++; $display("FAIL arst_recover got lat %0d info %h want 2/0807f", lat, info); end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        flush         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_op     = '0;
        bus.in_prec   = 2'b00;
        bus.out_ready = 1'b0;
        test_reset();
        test_double();
        test_single();
        test_half();
        test_illegal();
        test_backpressure();
        test_back_to_back();
        test_flush();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
